// File: rtl/program_loader.sv
// program_loader
//   Assembles instruction words from a byte stream (MSB-first) and writes
//   them to consecutive instruction-memory addresses starting at 0. A load
//   ends when HALT_WORD is written or when the last address has been written.
//   The pipeline is enabled only once the load is finished.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous, active-low reset
//   i_rx_data         received byte, valid while i_rx_done=1
//   i_rx_done         one-cycle strobe for i_rx_data
//   i_restart         start a new load from address 0 (honoured when done)
//   o_write_inst_mem  instruction memory write strobe (one cycle per word)
//   o_inst_mem_addr   word address for the write (holds between writes)
//   o_inst_mem_data   word to write (holds between writes)
//   o_enable          pipeline run enable, high once loading is finished
//   o_done            load complete
//   o_overrun         sticky: a byte arrived while it could not be accepted
module program_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_restart,
    output logic                  o_write_inst_mem,
    output logic [ADDR_WIDTH-1:0] o_inst_mem_addr,
    output logic [DATA_WIDTH-1:0] o_inst_mem_data,
    output logic                  o_enable,
    output logic                  o_done,
    output logic                  o_overrun
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      byte_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_shifted;

    // Word register with the incoming byte appended at the LSB end; after
    // BYTES shifts the first byte received sits in the top byte lane.
    always_comb begin
        word_shifted = (word_q << 8) | DATA_WIDTH'(i_rx_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= RECV;
            byte_cnt         <= '0;
            addr_q           <= '0;
            word_q           <= '0;
            o_write_inst_mem <= 1'b0;
            o_inst_mem_addr  <= '0;
            o_inst_mem_data  <= '0;
            o_enable         <= 1'b0;
            o_done           <= 1'b0;
            o_overrun        <= 1'b0;
        end else begin
            case (state)
                RECV: begin
                    if (i_rx_done) begin
                        word_q <= word_shifted;
                        if (byte_cnt == LAST_BYTE) begin
                            // Strobe and write data are registered here so
                            // they are visible for exactly the WRITE cycle.
                            byte_cnt         <= '0;
                            state            <= WRITE;
                            o_write_inst_mem <= 1'b1;
                            o_inst_mem_addr  <= addr_q;
                            o_inst_mem_data  <= word_shifted;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                WRITE: begin
                    o_write_inst_mem <= 1'b0;
                    if (i_rx_done) begin
                        o_overrun <= 1'b1;
                    end
                    // Halt word or last address ends the load without
                    // advancing the address (no wrap back to 0).
                    if (o_inst_mem_data == HALT_WORD || addr_q == '1) begin
                        state    <= DONE;
                        o_done   <= 1'b1;
                        o_enable <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        state  <= RECV;
                    end
                end

                DONE: begin
                    // Restart wins over a simultaneous byte, which is dropped
                    // without flagging an overrun.
                    if (i_restart) begin
                        state     <= RECV;
                        addr_q    <= '0;
                        byte_cnt  <= '0;
                        o_overrun <= 1'b0;
                        o_done    <= 1'b0;
                        o_enable  <= 1'b0;
                    end else if (i_rx_done) begin
                        o_overrun <= 1'b1;
                    end
                end

                default: begin
                    state <= RECV;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Self-checking bench for program_loader. A queue-based reference model
//   tracks the bytes of the word in progress, the pending write and the
//   finished flag; every falling edge the DUT outputs are compared with it.
//   Directed sequences additionally check the logged writes against
//   hand-computed address/data pairs.
module tb_program_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_done = 1'b0;
    logic          restart = 1'b0;
    logic          o_write_inst_mem;
    logic [AW-1:0] o_inst_mem_addr;
    logic [DW-1:0] o_inst_mem_data;
    logic          o_enable;
    logic          o_done;
    logic          o_overrun;

    program_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .HALT_WORD (HALT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rx_data       (rx_data),
        .i_rx_done       (rx_done),
        .i_restart       (restart),
        .o_write_inst_mem(o_write_inst_mem),
        .o_inst_mem_addr (o_inst_mem_addr),
        .o_inst_mem_data (o_inst_mem_data),
        .o_enable        (o_enable),
        .o_done          (o_done),
        .o_overrun       (o_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_bytes[$];
    bit          m_wr;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    int          m_next;
    bit          m_fin;
    bit          m_ovr;

    task automatic model_reset();
        m_bytes.delete();
        m_wr   = 0;
        m_addr = '0;
        m_data = '0;
        m_next = 0;
        m_fin  = 0;
        m_ovr  = 0;
    endtask

    task automatic model_step();
        if (m_wr) begin
            m_wr = 0;
            if (rx_done) m_ovr = 1;
            if (m_data == HALT || m_next == 255) m_fin = 1;
            else m_next++;
        end else if (m_fin) begin
            if (restart) begin
                m_fin  = 0;
                m_next = 0;
                m_ovr  = 0;
                m_bytes.delete();
            end else if (rx_done) begin
                m_ovr = 1;
            end
        end else if (rx_done) begin
            m_bytes.push_back(rx_data);
            if (m_bytes.size() == 4) begin
                m_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_addr = 8'(m_next);
                m_wr   = 1;
                m_bytes.delete();
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_step();
    end

    // ---------------- compare + write log ----------------
    logic [39:0] wlog[$];

    always @(negedge clk) begin
        if (o_write_inst_mem) wlog.push_back({o_inst_mem_addr, o_inst_mem_data});
        check("write_strobe", o_write_inst_mem, m_wr);
        check("mem_addr", o_inst_mem_addr, m_addr);
        check("mem_data", o_inst_mem_data, m_data);
        check("done", o_done, m_fin);
        check("enable", o_enable, m_fin);
        check("overrun", o_overrun, m_ovr);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Asserts reset between clock edges so the async path is exercised.
    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_write", o_write_inst_mem, 1'b0);
        check("async_rst_addr", o_inst_mem_addr, 8'h00);
        check("async_rst_done", o_done, 1'b0);
        check("async_rst_overrun", o_overrun, 1'b0);
        idle(2);
        rst = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!o_done && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("wait_done", o_done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr0_writes;
        logic [31:0] w;
        model_reset();
        idle(2);
        check("reset_enable", o_enable, 1'b0);
        check("reset_data", o_inst_mem_data, 32'h0);
        rst = 1'b1;

        // Byte ordering and one-cycle write latency
        wlog.delete();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("order_strobe", o_write_inst_mem, 1'b1);
        check("order_data", o_inst_mem_data, 32'h12345678);
        check("order_addr", o_inst_mem_addr, 8'h00);
        idle(1);

        // Normal load ending in the halt word
        do_reset();
        wlog.delete();
        send_word(32'h0000000A); idle(1);
        send_word(32'h00000014); idle(1);
        send_word(32'hFFFFFFFF);
        wait_done(5);
        idle(2);
        check("normal_nwrites", wlog.size(), 3);
        check("normal_w0", wlog[0], {8'd0, 32'h0000000A});
        check("normal_w1", wlog[1], {8'd1, 32'h00000014});
        check("normal_w2", wlog[2], {8'd2, 32'hFFFFFFFF});
        check("normal_enable", o_enable, 1'b1);
        check("normal_addr_hold", o_inst_mem_addr, 8'd2);

        // Restart together with a byte in DONE: byte dropped, no overrun
        rx_data = 8'h55; rx_done = 1'b1; restart = 1'b1;
        idle(1);
        rx_done = 1'b0; restart = 1'b0;
        check("rst_rx_overrun", o_overrun, 1'b0);
        check("rst_rx_done", o_done, 1'b0);

        // Overrun: a byte during the WRITE cycle is dropped
        do_reset();
        wlog.delete();
        send_word(32'h01020304);
        send_byte(8'hEE);
        check("ovr_flag", o_overrun, 1'b1);
        send_word(32'h05060708);
        idle(1);
        check("ovr_nwrites", wlog.size(), 2);
        check("ovr_w0", wlog[0], {8'd0, 32'h01020304});
        check("ovr_w1", wlog[1], {8'd1, 32'h05060708});

        // Full memory: 256 non-halt words
        do_reset();
        wlog.delete();
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            w[31:24] = 8'($urandom_range(0, 254));
            send_word(w);
            idle(1);
        end
        wait_done(5);
        idle(1);
        addr0_writes = 0;
        foreach (wlog[i]) if (wlog[i][39:32] == 8'h00) addr0_writes++;
        check("full_nwrites", wlog.size(), 256);
        check("full_last_addr", wlog[255][39:32], 8'hFF);
        check("full_addr0_once", addr0_writes, 1);
        check("full_done", o_done, 1'b1);

        // Restart from DONE, then a restart during RECV is ignored
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
        check("restart_enable_drop", o_enable, 1'b0);
        wlog.delete();
        send_word(32'h11223344);
        idle(1);
        send_byte(8'hAA); send_byte(8'hBB);
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
        send_byte(8'hCC); send_byte(8'hDD);
        idle(1);
        check("restart_nwrites", wlog.size(), 2);
        check("restart_w0", wlog[0], {8'd0, 32'h11223344});
        check("restart_recv_ignored", wlog[1], {8'd1, 32'hAABBCCDD});

        // Mid-word reset discards the partial word
        do_reset();
        wlog.delete();
        send_byte(8'h99); send_byte(8'h88);
        do_reset();
        send_word(32'hCAFE0001);
        idle(1);
        check("midrst_nwrites", wlog.size(), 1);
        check("midrst_w0", wlog[0], {8'd0, 32'hCAFE0001});

        // Reset in the WRITE cycle suppresses the strobe
        do_reset();
        wlog.delete();
        send_word(32'h0BADF00D);
        do_reset();
        idle(2);
        check("wrrst_nwrites", wlog.size(), 0);

        // Randomized traffic checked against the model every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                rx_done = 1'b0;
                restart = 1'b0;
                do_reset();
            end else begin
                rx_done = ($urandom_range(0, 4) < 2);
                rx_data = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
                restart = m_fin ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
                idle(1);
            end
        end
        rx_done = 1'b0;
        restart = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
